// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter that shares one UART transmit byte stream
//   among N requesters. The granted requester keeps the stream until it hands
//   over a byte flagged last, or until it stays idle for TIMEOUT cycles.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  idle cycles of the granted requester before the grant is revoked (>=2)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_data[8*N-1:0]     byte from requester i at [8*i+7:8*i]
//   req_valid/req_last    per-requester valid and end-of-packet flag
//   req_ready             per-requester accept (only the owner can see it high)
//   out_data/out_valid    byte stream to the UART transmitter
//   out_ready             transmitter accepts byte
//   grant                 one-hot current owner, zero when idle
//   timeout               one-cycle pulse when the stall timer revokes the grant
//
// Build option
//   UART_ARB_TAG_EN       when defined, each packet is preceded by a header byte
//                         {5'b10100, idx[2:0]} so packets identify their source.

module uart_tx_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           timeout
);

    // Stall counter wide enough for TIMEOUT-1, clamped to 12..32 bits.
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 12) ? 12 : ((CW_RAW > 32) ? 32 : CW_RAW);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE, XFER, TAG} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t          state_q, state_d;
    logic [2:0]      gidx_q, gidx_d;   // index of the current owner
    logic [2:0]      ptr_q, ptr_d;     // last served requester
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [2:0]      pick;
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            ptr_q   <= 3'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Round-robin pick: first valid requester scanning from ptr+1 with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_valid[i] && ((int'(ptr_q) + k) % N == i)) begin
                    found = 1'b1;
                    pick  = 3'(i);
                end
            end
        end
    end

    // Owner's signals and the one-hot grant view of gidx_q.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx_q == 3'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                if (state_q != IDLE) grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        out_data  = '0;
        req_ready = '0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d = pick;
                    cnt_d  = '0;
`ifdef UART_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                out_valid = 1'b1;
                out_data  = {5'b10100, gidx_q};
                cnt_d     = '0;
                if (out_ready) state_d = XFER;
            end
`endif
            XFER: begin
                out_valid = sel_valid;
                out_data  = sel_data;
                for (int i = 0; i < N; i++) begin
                    if (gidx_q == 3'(i)) req_ready[i] = out_ready;
                end
                if (sel_valid && out_ready) begin
                    // A handshake always beats an expiring timer.
                    cnt_d = '0;
                    if (sel_last) begin
                        state_d = IDLE;
                        ptr_d   = gidx_q;
                    end
                end else if (!sel_valid) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                        ptr_d   = gidx_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                // valid but not ready: back-pressure, counter holds
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
